// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready pipeline applying one of eight bitwise ops to two operands,
// with an optional accumulator feeding back the last accepted result as operand A.
module bitwise_logic_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] result;
  logic             s2_load_ok;
  logic             s1_move;
  logic             accept;

  // Handshake decode; in_ready intentionally depends combinationally on out_ready.
  always_comb begin
    s2_load_ok = !out_valid_q || out_ready;
    s1_move    = s1_valid_q && s2_load_ok;
    in_ready   = !s1_valid_q || s2_load_ok;
    accept     = in_valid && in_ready;
  end

  // Bitwise operation on the offered beat; A comes from the accumulator when chaining.
  always_comb begin
    opa    = acc_en ? acc_q : in1;
    result = '0;
    unique case (op)
      3'd0: result = opa & in2;
      3'd1: result = opa | in2;
      3'd2: result = opa ^ in2;
      3'd3: result = ~(opa & in2);
      3'd4: result = ~(opa | in2);
      3'd5: result = ~(opa ^ in2);
      3'd6: result = ~opa;
      3'd7: result = in2;
      default: result = '0;
    endcase
  end

  // Next state for accumulator and both pipeline stages.
  always_comb begin
    acc_d       = acc_q;
    s1_data_d   = s1_data_q;
    s1_valid_d  = s1_valid_q;
    out_d       = out_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;

    // Stage 2 takes the old stage-1 beat; stage 1 may refill on the same edge.
    if (s1_move) begin
      out_d       = s1_data_q;
      zero_d      = (s1_data_q == '0);
      neg_d       = s1_data_q[WIDTH-1];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      acc_d      = result;
      s1_data_d  = result;
      s1_valid_d = 1'b1;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset discards in-flight beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      s1_data_q   <= '0;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      s1_data_q   <= s1_data_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench: expected results are queued at accept and compared at output transfer.
module tb_bitwise_logic_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        in_valid, in_ready, acc_en, out_valid, out_ready, zero, neg;
  logic [15:0] in1, in2, out;
  logic [2:0]  op;

  // 1-bit instance
  logic       w1_in_valid, w1_in_ready, w1_acc_en, w1_out_valid, w1_out_ready;
  logic       w1_zero, w1_neg;
  logic [0:0] w1_in1, w1_in2, w1_out;
  logic [2:0] w1_op;
  logic       w1_rand_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] q16[$];
  logic        q1[$];

  bitwise_logic_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op(op), .acc_en(acc_en), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zero(zero), .neg(neg)
  );

  bitwise_logic_pipe #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .in1(w1_in1), .in2(w1_in2), .op(w1_op), .acc_en(w1_acc_en), .out_valid(w1_out_valid),
    .out_ready(w1_out_ready), .out(w1_out), .zero(w1_zero), .neg(w1_neg)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic f_op1(input logic [2:0] o, input logic a, input logic b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return b;
    endcase
  endfunction

  // Offer one beat until accepted; expected result is queued at the accepting edge.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                        input logic ae, input logic [15:0] exp, output int stalls);
    logic accepted;
    accepted = 1'b0;
    stalls   = 0;
    in_valid = 1'b1; in1 = a; in2 = b; op = o; acc_en = ae;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready && !reset) begin
        q16.push_back(exp);
        accepted = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    check_eq("send16_accept", accepted, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send1(input logic a, input logic b, input logic [2:0] o);
    logic accepted;
    accepted    = 1'b0;
    w1_in_valid = 1'b1; w1_in1 = a; w1_in2 = b; w1_op = o; w1_acc_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (w1_in_ready && !reset) begin
        q1.push_back(f_op1(o, a, b));
        accepted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("send1_accept", accepted, 1);
    @(posedge clk); #1;
    w1_in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q16.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    check_eq("drain16_empty", q16.size(), 0);
    check_eq("drain1_empty", q1.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor, 16-bit instance
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      check_eq("q16_nonempty", q16.size() != 0, 1);
      if (q16.size() != 0) begin
        logic [15:0] e;
        e = q16.pop_front();
        check_eq("out16", out, e);
        check_eq("zero16", zero, e == 16'h0);
        check_eq("neg16", neg, e[15]);
      end
    end
  end

  // Output monitor, 1-bit instance
  always @(negedge clk) begin
    if (!reset && w1_out_valid && w1_out_ready) begin
      check_eq("q1_nonempty", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        logic e;
        e = q1.pop_front();
        check_eq("out1", w1_out, e);
        check_eq("zero1", w1_zero, !e);
        check_eq("neg1", w1_neg, e);
      end
    end
  end

  // Random consumer stalls for the 1-bit instance
  always @(posedge clk) begin
    #1 w1_out_ready = w1_rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    reset = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; op = '0; acc_en = 1'b0;
    out_ready = 1'b1;
    w1_in_valid = 1'b0; w1_in1 = '0; w1_in2 = '0; w1_op = '0; w1_acc_en = 1'b0;
    w1_rand_ready = 1'b0; w1_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out", out, 0);
    check_eq("rst_zero", zero, 0);
    check_eq("rst_neg", neg, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single beat: latency and one-cycle out_valid
    send16(16'hF0F0, 16'hFF00, 3'd0, 1'b0, 16'hF000, st);
    @(negedge clk); check_eq("lat_not_yet", out_valid, 0);
    @(negedge clk); check_eq("lat_valid", out_valid, 1);
    check_eq("lat_out", out, 16'hF000);
    check_eq("lat_neg", neg, 1);
    @(negedge clk); check_eq("lat_drop", out_valid, 0);
    @(posedge clk); #1;

    // Stream all eight ops
    send16(16'h00FF, 16'h0F0F, 3'd0, 1'b0, 16'h000F, st); check_eq("stream_stall0", st, 0);
    send16(16'h00FF, 16'h0F0F, 3'd1, 1'b0, 16'h0FFF, st); check_eq("stream_stall1", st, 0);
    send16(16'h00FF, 16'h0F0F, 3'd2, 1'b0, 16'h0FF0, st); check_eq("stream_stall2", st, 0);
    send16(16'h00FF, 16'h0F0F, 3'd3, 1'b0, 16'hFFF0, st); check_eq("stream_stall3", st, 0);
    send16(16'h00FF, 16'h0F0F, 3'd4, 1'b0, 16'hF000, st); check_eq("stream_stall4", st, 0);
    send16(16'h00FF, 16'h0F0F, 3'd5, 1'b0, 16'hF00F, st); check_eq("stream_stall5", st, 0);
    send16(16'h00FF, 16'h0F0F, 3'd6, 1'b0, 16'hFF00, st); check_eq("stream_stall6", st, 0);
    send16(16'h00FF, 16'h0F0F, 3'd7, 1'b0, 16'h0F0F, st); check_eq("stream_stall7", st, 0);
    drain();

    // Accumulator chain; in1 set to junk to show it is ignored under acc_en
    send16(16'h5A5A, 16'hFFFF, 3'd7, 1'b0, 16'hFFFF, st);
    send16(16'h5A5A, 16'h0FF0, 3'd0, 1'b1, 16'h0FF0, st);
    send16(16'h5A5A, 16'h0FF0, 3'd2, 1'b1, 16'h0000, st); check_eq("acc_stall", st, 0);
    drain();

    // Backpressure: two beats fill the pipe, output freezes on beat 1
    out_ready = 1'b0;
    send16(16'h0, 16'h1111, 3'd7, 1'b0, 16'h1111, st);
    send16(16'h0, 16'h2222, 3'd7, 1'b0, 16'h2222, st);
    in_valid = 1'b1; in2 = 16'h3333; op = 3'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_out_frozen", out, 16'h1111);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send16(16'h0, 16'h3333, 3'd7, 1'b0, 16'h3333, st); check_eq("bp_stall3", st, 0);
    send16(16'h0, 16'h4444, 3'd7, 1'b0, 16'h4444, st); check_eq("bp_stall4", st, 0);
    drain();

    // Reset with both stages full and acc=1234
    out_ready = 1'b0;
    send16(16'h0, 16'h1234, 3'd7, 1'b0, 16'h1234, st);
    send16(16'h0, 16'h1234, 3'd7, 1'b0, 16'h1234, st);
    reset = 1'b1;
    q16.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("mr_out_valid", out_valid, 0);
    check_eq("mr_out", out, 0);
    check_eq("mr_zero", zero, 0);
    check_eq("mr_neg", neg, 0);
    check_eq("mr_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send16(16'hFFFF, 16'h0001, 3'd1, 1'b1, 16'h0001, st);
    drain();

    // WIDTH=1: exhaustive operands over all ops with random consumer stalls
    w1_rand_ready = 1'b1;
    for (int o = 0; o < 8; o++)
      for (int a = 0; a < 2; a++)
        for (int b = 0; b < 2; b++)
          send1(1'(a), 1'(b), 3'(o));
    w1_rand_ready = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_pipe.md
# bitwise_logic_pipe

Parametrised, pipelined successor to the 16-bit bitwise gate blocks. It applies one of eight bitwise operations to two WIDTH-bit operands. It can optionally chain each result into the next beat through an internal accumulator. Results leave through a valid/ready handshake after a fixed two-stage pipeline. It sits between operand producers (register file / bus) and consumers that may stall.

## Interface
- WIDTH, 16, operand/result width in bits (≥1)
- clk  input  1  rising-edge clock, only clock
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- in_valid  input  1  operand beat offered
- in_ready  output  1  block can accept beat this cycle
- in1  input  WIDTH  operand A (ignored when acc_en=1)
- in2  input  WIDTH  operand B
- op  input  3  operation select, captured with beat
- acc_en  input  1  use accumulator as operand A for this beat
- out_valid  output  1  result beat available
- out_ready  input  1  consumer takes result this cycle
- out  output  WIDTH  result
- zero  output  1  out == 0
- neg  output  1  out[WIDTH-1]

## Operation
- op encoding (A = acc_en ? acc : in1, B = in2): 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 PASS B. All eight codes are legal.
- Accept: in_valid && in_ready at a rising edge.
- On accept:
  - result computed combinationally from the current inputs;
  - result written to stage-1 register (s1_data, s1_valid=1);
  - acc register loaded with the same result.
- acc changes only on accept or reset, so back-to-back acc_en beats chain without bubbles or hazards.
- Stage 2 (output register) holds out, zero, neg and out_valid.
- s2_load_ok = !out_valid || out_ready.
- s1 moves to s2 when s1_valid && s2_load_ok.
- in_ready = !s1_valid || s2_load_ok. This is a combinational path from out_ready; it is intended.
- Simultaneous s1→s2 move and new accept: s1 takes the new beat and s2 takes the old one. No loss, no duplication.
- Stall (out_valid && !out_ready): out, zero, neg, out_valid hold stable.
  - s1 fills if it is empty; then in_ready=0.
  - Max 2 beats in flight.
- in_valid=0: nothing is accepted and acc holds; in1, in2, op, acc_en are don't-care.
- Beats emerge strictly in acceptance order.

## Timing
- Reset (any cycle, including mid-stream): s1_valid=0, out_valid=0, out=0, zero=0, neg=0, acc=0.
  - In-flight beats are discarded.
  - in_ready=1 from the first cycle after reset deasserts.
  - An accept coincident with reset is ignored; acc stays 0.
- Latency: a beat accepted at edge N gives out_valid=1 after edge N+1 (visible during cycle N+1→N+2), provided out_ready was not stalling.
- Throughput: 1 beat/cycle with out_ready held high.
- zero and neg are registered with out and always describe the current out.
- out_valid drops after the edge where out_valid && out_ready, unless a new beat loads s2 at the same edge.
- No combinational path from in1, in2, op or acc_en to any output.

## Test plan
- Reset, then WIDTH=16, out_ready=1, one beat in1=16'hF0F0, in2=16'hFF00, op=0 → two edges later out=16'hF000, out_valid=1 for one cycle, zero=0, neg=1.
- Streaming all 8 ops on in1=16'h00FF, in2=16'h0F0F, one per cycle, out_ready=1 → in_ready stays 1. Outputs in order:
  - 0 AND: 000F
  - 1 OR: 0FFF
  - 2 XOR: 0FF0
  - 3 NAND: FFF0
  - 4 NOR: F000
  - 5 XNOR: F00F
  - 6 NOT A: FF00
  - 7 PASS B: 0F0F
- Accumulator chain, back-to-back: beat1 op=7 in2=16'hFFFF; beat2 acc_en=1, op=0, in2=16'h0FF0; beat3 acc_en=1, op=2, in2=16'h0FF0 → outputs FFFF, 0FF0, 0000. On the third result zero=1, neg=0.
- Backpressure: out_ready=0 while offering 4 beats → 2 beats accepted, in_ready=0 from the cycle after the second accept, out frozen on beat1. Then out_ready=1 → beats 3 and 4 accepted at one per cycle and all four results delivered in order, with no loss or duplication.
- Reset mid-operation: reset asserted with both stages full and acc=16'h1234 → next cycle out_valid=0, out=0, zero=0, neg=0, in_ready=1. Then an acc_en=1 beat with op=1, in2=16'h0001 → out=16'h0001, proving acc=0.
- WIDTH=1 instance, exhaustive in1/in2 over all ops with random out_ready → every result matches the op table, zero = !out, neg = out.
